rr_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single memory/ALU bus among N_REQ requesters
//  (ROM wr, ROM rd, RAM wr, RAM rd, ALU by default).
//  - Grant is held while the owner keeps req high, up to MAX_HOLD cycles.
//  - One-cycle turnaround between owners.
//  - A timed-out requester is locked out until it drops req.

---
 rtl/rr_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_rr_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for the shared memory/ALU bus. One owner at a time, tenure
// bounded by MAX_HOLD, one-cycle turnaround, and timed-out requesters locked out
// until they drop their request.
module rr_bus_arbiter #(
  parameter int unsigned N_REQ    = 5,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned ID_W     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             busy,
  output logic             timeout,
  output logic [ID_W-1:0]  timeout_id
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] lockout_q, lockout_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;
  logic [ID_W-1:0]  timeout_id_q, timeout_id_d;

  logic [N_REQ-1:0] elig;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  int unsigned      scan_idx;

  assign elig = req & ~lockout_q;

  // Pick the first eligible requester scanning upward from ptr, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= N_REQ) begin
        scan_idx = scan_idx - N_REQ;
      end
      if (!win_found && elig[scan_idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  // Next-state logic: arbitration, tenure bookkeeping, release and lockout.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    timeout_d    = 1'b0;
    timeout_id_d = '0;
    // A dropped request always clears its lockout; the owner's timeout set below
    // cannot collide because the owner's req is high on that path.
    lockout_d    = lockout_q & req;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
          gnt_id_d   = win_id;
          hold_cnt_d = CntW'(1);
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (req[gnt_id_q] && (hold_cnt_q < CntW'(MAX_HOLD))) begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end else begin
          gnt_d      = '0;
          gnt_id_d   = '0;
          hold_cnt_d = '0;
          ptr_d      = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);
          state_d    = StTurn;
          if (req[gnt_id_q]) begin
            timeout_d           = 1'b1;
            timeout_id_d        = gnt_id_q;
            lockout_d[gnt_id_q] = 1'b1;
          end
        end
      end
      StTurn: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      hold_cnt_q   <= '0;
      lockout_q    <= '0;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      lockout_q    <= lockout_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_id     = gnt_id_q;
  assign busy       = |gnt_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: a cycle-level reference model pushes the expected
// outputs for each driven cycle into a queue; they are popped and compared after
// the clock edge. Directed scenarios add a few end-to-end checks.
module tb_rr_bus_arbiter;

  localparam int unsigned N    = 5;
  localparam int unsigned MAXH = 16;
  localparam int unsigned IDW  = 3;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;
  logic [IDW-1:0] timeout_id;

  rr_bus_arbiter #(
    .N_REQ   (N),
    .MAX_HOLD(MAXH),
    .ID_W    (IDW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .timeout_id(timeout_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;
    logic [IDW-1:0] timeout_id;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: 0 = idle, 1 = granted, 2 = turnaround; m_owner < 0 means no owner.
  int         m_state = 0;
  int         m_ptr   = 0;
  int         m_cnt   = 0;
  int         m_owner = -1;
  logic [N-1:0] m_lock = '0;

  // Count one comparison and report it if the observed value differs.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  // Advance the model by one edge with the given inputs and queue its outputs.
  task automatic model_push(input logic [N-1:0] r, input logic rs);
    exp_t         e;
    logic [N-1:0] next_lock;
    int           c;
    bit           to;
    int           to_id;
    to    = 0;
    to_id = 0;
    if (rs) begin
      m_state = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      m_lock  = '0;
      m_owner = -1;
    end else begin
      next_lock = m_lock & r;
      if (m_state == 0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (m_owner < 0 && r[c] && !m_lock[c]) begin
            m_owner = c;
            m_cnt   = 1;
            m_state = 1;
          end
        end
      end else if (m_state == 1) begin
        if (r[m_owner] && m_cnt < MAXH) begin
          m_cnt++;
        end else begin
          if (r[m_owner]) begin
            to                 = 1;
            to_id              = m_owner;
            next_lock[m_owner] = 1'b1;
          end
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_cnt   = 0;
          m_state = 2;
        end
      end else begin
        m_state = 0;
      end
      m_lock = next_lock;
    end
    e.gnt        = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.gnt_id     = (m_owner >= 0) ? IDW'(m_owner) : '0;
    e.busy       = (m_owner >= 0);
    e.timeout    = to;
    e.timeout_id = IDW'(to_id);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the queued expectation.
  task automatic step(input logic [N-1:0] r, input logic rs);
    exp_t e;
    req   = r;
    reset = rs;
    model_push(r, rs);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("gnt", 32'(gnt), 32'(e.gnt));
    check("gnt_id", 32'(gnt_id), 32'(e.gnt_id));
    check("busy", 32'(busy), 32'(e.busy));
    check("timeout", 32'(timeout), 32'(e.timeout));
    if (e.timeout) begin
      check("timeout_id", 32'(timeout_id), 32'(e.timeout_id));
    end
  endtask

  initial begin
    int           order[$];
    logic         prev_busy;
    int           n_g2;
    int           n_to;
    int           n_tenure;
    logic [N-1:0] r;

    // Reset held with every request high: nothing granted, then req0 wins first.
    step(5'b11111, 1'b1);
    step(5'b11111, 1'b1);
    step(5'b11111, 1'b0);
    check("first_owner", 32'(gnt), 32'h1);
    order.push_back(int'(gnt_id));
    prev_busy = busy;

    // Round robin: each owner drops req in its third grant cycle, re-raises next.
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      r = 5'b11111;
      if (m_state == 1 && m_cnt == 3) r[m_owner] = 1'b0;
      step(r, 1'b0);
      if (busy && !prev_busy) order.push_back(int'(gnt_id));
      prev_busy = busy;
    end
    check("rr_count", 32'(order.size()), 32'd6);
    for (int i = 0; i < order.size(); i++) begin
      check("rr_order", 32'(order[i]), 32'(i % N));
    end

    // Pointer wrap: after req4 releases, req1 beats req2.
    repeat (4) step(5'b00000, 1'b0);
    step(5'b10000, 1'b0);
    step(5'b10000, 1'b0);
    step(5'b00000, 1'b0);
    step(5'b00110, 1'b0);
    step(5'b00110, 1'b0);
    check("wrap_owner", 32'(gnt_id), 32'd1);

    // Timeout: req2 held forever, req3 waiting.
    repeat (4) step(5'b00000, 1'b0);
    n_g2 = 0;
    n_to = 0;
    for (int i = 0; i < 20; i++) begin
      step(5'b01100, 1'b0);
      if (gnt[2]) n_g2++;
      if (timeout) begin
        n_to++;
        check("to_id_direct", 32'(timeout_id), 32'd2);
      end
    end
    check("to_hold_cycles", 32'(n_g2), 32'd16);
    check("to_pulses", 32'(n_to), 32'd1);
    check("to_next_owner", 32'(gnt_id), 32'd3);

    // req2 stays locked out while it keeps requesting.
    n_g2 = 0;
    for (int i = 0; i < 5; i++) begin
      step(5'b00100, 1'b0);
      if (gnt[2]) n_g2++;
    end
    check("locked_out", 32'(n_g2), 32'd0);
    step(5'b00000, 1'b0);
    step(5'b00100, 1'b0);
    check("regrant", 32'(gnt), 32'h4);
    repeat (4) step(5'b00000, 1'b0);

    // Lone requester: 4 cycles high, 1 low, four times.
    n_tenure  = 0;
    n_to      = 0;
    prev_busy = busy;
    for (int p = 0; p < 4; p++) begin
      for (int j = 0; j < 5; j++) begin
        step((j < 4) ? 5'b00001 : 5'b00000, 1'b0);
        if (busy && !prev_busy) n_tenure++;
        if (timeout) n_to++;
        if (busy) check("lone_id", 32'(gnt_id), 32'd0);
        prev_busy = busy;
      end
    end
    check("lone_tenures", 32'(n_tenure), 32'd4);
    check("lone_timeouts", 32'(n_to), 32'd0);
    repeat (2) step(5'b00000, 1'b0);

    // Reset mid-tenure: grant drops, no timeout, pointer back to 0 so req3 beats req4.
    step(5'b01000, 1'b0);
    step(5'b01000, 1'b0);
    step(5'b01000, 1'b1);
    check("rst_mid_gnt", 32'(gnt), 32'h0);
    check("rst_mid_to", 32'(timeout), 32'h0);
    step(5'b11000, 1'b0);
    check("post_reset_owner", 32'(gnt_id), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
